// File: rtl/ias_fetch_unit.sv
// IAS instruction-fetch stage: fetches 40-bit words, splits them into left/right
// 20-bit instructions and issues them to execute over a valid/ready handshake.
//
// state | meaning
// FETCH | drive mem_req with PC, latch MAR
// WAIT  | waiting for the memory word of the outstanding request
// ISSUE | presenting an instruction (left, then right from IBR)
// DRAIN | a branch cancelled the outstanding read; swallow its response
module ias_fetch_unit #(
    parameter int ADDR_W = 12,
    parameter int OPC_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_valid,
    input  logic [2*(OPC_W+ADDR_W)-1:0] mem_rdata,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [OPC_W-1:0]            opcode,
    output logic [ADDR_W-1:0]           address,
    input  logic                        branch_valid,
    input  logic [ADDR_W-1:0]           branch_target,
    input  logic                        branch_right,
    output logic [ADDR_W-1:0]           pc,
    output logic                        ibr_full
);
    localparam int INSTR_W = OPC_W + ADDR_W;
    localparam int WORD_W  = 2 * INSTR_W;

    typedef enum logic [1:0] {FETCH, WAIT, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [INSTR_W-1:0]  ibr_q, ibr_d;
    logic                ibr_full_q, ibr_full_d;
    logic                start_right_q, start_right_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                instr_valid_q, instr_valid_d;

    logic [INSTR_W-1:0]  left_w;
    logic [INSTR_W-1:0]  right_w;

    assign left_w  = mem_rdata[WORD_W-1:INSTR_W];
    assign right_w = mem_rdata[INSTR_W-1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mar_d         = mar_q;
        ibr_d         = ibr_q;
        ibr_full_d    = ibr_full_q;
        start_right_d = start_right_q;
        opcode_d      = opcode_q;
        address_d     = address_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            FETCH: begin
                mar_d   = pc_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    if (!start_right_q) begin
                        opcode_d   = left_w[INSTR_W-1:ADDR_W];
                        address_d  = left_w[ADDR_W-1:0];
                        ibr_d      = right_w;
                        ibr_full_d = 1'b1;
                    end else begin
                        opcode_d      = right_w[INSTR_W-1:ADDR_W];
                        address_d     = right_w[ADDR_W-1:0];
                        ibr_full_d    = 1'b0;
                        pc_d          = pc_q + ADDR_W'(1);
                        start_right_d = 1'b0;
                    end
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_valid_q && instr_ready) begin
                    if (ibr_full_q) begin
                        opcode_d   = ibr_q[INSTR_W-1:ADDR_W];
                        address_d  = ibr_q[ADDR_W-1:0];
                        ibr_full_d = 1'b0;
                        pc_d       = pc_q + ADDR_W'(1);
                    end else begin
                        instr_valid_d = 1'b0;
                        state_d       = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (mem_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // A redirect wins over the accept and over a same-cycle memory response.
        if (branch_valid) begin
            pc_d          = branch_target;
            start_right_d = branch_right;
            instr_valid_d = 1'b0;
            ibr_full_d    = 1'b0;
            if (state_q == DRAIN || (state_q == WAIT && !mem_valid))
                state_d = DRAIN;
            else
                state_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= '0;
            mar_q         <= '0;
            ibr_q         <= '0;
            ibr_full_q    <= 1'b0;
            start_right_q <= 1'b0;
            opcode_q      <= '0;
            address_q     <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mar_q         <= mar_d;
            ibr_q         <= ibr_d;
            ibr_full_q    <= ibr_full_d;
            start_right_q <= start_right_d;
            opcode_q      <= opcode_d;
            address_q     <= address_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = mem_req ? pc_q : mar_q;
    assign instr_valid = instr_valid_q;
    assign opcode      = opcode_q;
    assign address     = address_q;
    assign pc          = pc_q;
    assign ibr_full    = ibr_full_q;
endmodule
